// File: rtl/video_stream_switch.sv
// video_stream_switch: routes one of NUM_SRC latency-matched RGB+sync video streams to a
// single registered output. Source changes are deferred to a frame boundary so that no frame
// is ever torn. Also tracks the output pixel position and can paint a crosshair overlay.
module video_stream_switch #(
  parameter int                  NUM_SRC = 8,
  parameter int                  SEL_W   = 4,
  parameter int                  DATA_W  = 8,
  parameter int                  POS_W   = 12,
  parameter logic [3*DATA_W-1:0] OVL_RGB = 24'hFF0000
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic [NUM_SRC*DATA_W-1:0] iR,
  input  logic [NUM_SRC*DATA_W-1:0] iG,
  input  logic [NUM_SRC*DATA_W-1:0] iB,
  input  logic [NUM_SRC-1:0]        iHSync,
  input  logic [NUM_SRC-1:0]        iVSync,
  input  logic [NUM_SRC-1:0]        iLineValid,
  input  logic [NUM_SRC-1:0]        iFrameValid,
  input  logic [SEL_W-1:0]          iSel,
  input  logic                      iOvlEn,
  input  logic [POS_W-1:0]          iXMark,
  input  logic [POS_W-1:0]          iYMark,
  output logic [DATA_W-1:0]         oR,
  output logic [DATA_W-1:0]         oG,
  output logic [DATA_W-1:0]         oB,
  output logic                      oHSync,
  output logic                      oVSync,
  output logic                      oLineValid,
  output logic                      oFrameValid,
  output logic [POS_W-1:0]          oX,
  output logic [POS_W-1:0]          oY,
  output logic [SEL_W-1:0]          oSelActive,
  output logic                      oPending,
  output logic                      oBadSel
);

  localparam logic [DATA_W-1:0] OVL_R = OVL_RGB[2*DATA_W +: DATA_W];
  localparam logic [DATA_W-1:0] OVL_G = OVL_RGB[DATA_W +: DATA_W];
  localparam logic [DATA_W-1:0] OVL_B = OVL_RGB[0 +: DATA_W];

  typedef enum logic {RUN, PENDING} state_t;

  state_t             state;
  logic [SEL_W-1:0]   sel_active;
  logic [SEL_W-1:0]   sel_req;
  logic               sel_bad;
  logic               sel_cancel;
  logic               do_switch;

  logic [DATA_W-1:0]  r_p0, g_p0, b_p0;
  logic               hs_p0, vs_p0, lv_p0, fv_p0, vld_p0;
  logic               fv_req;
  logic               ovl_hit;

  logic [POS_W-1:0]   x_cnt, y_cnt;
  logic               prev_lv;

  // Position counters stop at full scale instead of wrapping back to zero.
  function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] v);
    return (v == {POS_W{1'b1}}) ? v : v + POS_W'(1);
  endfunction

  assign sel_bad    = (int'(iSel) >= NUM_SRC);
  assign sel_cancel = (state == PENDING) && !sel_bad && (iSel == sel_active);
  // Both the old and the requested source must be between frames at the same time.
  assign do_switch  = (state == PENDING) && !sel_cancel && !fv_p0 && !fv_req;
  assign oSelActive = sel_active;

  // ---- stage p0: combinational source mux, blanking of invalid pixels, overlay decision
  // Select the active source's pixel/syncs and the requested source's FrameValid.
  always_comb begin
    r_p0   = '0;
    g_p0   = '0;
    b_p0   = '0;
    hs_p0  = 1'b0;
    vs_p0  = 1'b0;
    lv_p0  = 1'b0;
    fv_p0  = 1'b0;
    fv_req = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_active == SEL_W'(k)) begin
        r_p0  = iR[k*DATA_W +: DATA_W];
        g_p0  = iG[k*DATA_W +: DATA_W];
        b_p0  = iB[k*DATA_W +: DATA_W];
        hs_p0 = iHSync[k];
        vs_p0 = iVSync[k];
        lv_p0 = iLineValid[k];
        fv_p0 = iFrameValid[k];
      end
      if (sel_req == SEL_W'(k)) begin
        fv_req = iFrameValid[k];
      end
    end
    vld_p0 = lv_p0 & fv_p0;
    if (!vld_p0) begin
      r_p0 = '0;
      g_p0 = '0;
      b_p0 = '0;
    end
  end

  assign ovl_hit = iOvlEn & vld_p0 & ((x_cnt == iXMark) | (y_cnt == iYMark));

  // Source-selection FSM: requests wait in PENDING until a common frame boundary.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state      <= RUN;
      sel_active <= '0;
      sel_req    <= '0;
      oPending   <= 1'b0;
      oBadSel    <= 1'b0;
    end else begin
      oBadSel <= sel_bad;
      case (state)
        RUN: begin
          if (!sel_bad && (iSel != sel_active)) begin
            sel_req  <= iSel;
            state    <= PENDING;
            oPending <= 1'b1;
          end
        end
        PENDING: begin
          if (sel_cancel) begin
            state    <= RUN;
            oPending <= 1'b0;
          end else if (do_switch) begin
            sel_active <= sel_req;
            state      <= RUN;
            oPending   <= 1'b0;
          end else if (!sel_bad) begin
            sel_req <= iSel;
          end
        end
        default: begin
          state    <= RUN;
          oPending <= 1'b0;
        end
      endcase
    end
  end

  // X/Y position of the muxed stream; a switch restarts tracking without a false line edge.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      prev_lv <= 1'b0;
    end else if (do_switch) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      prev_lv <= 1'b0;
    end else begin
      prev_lv <= lv_p0;
      if (!lv_p0)      x_cnt <= '0;
      else if (vld_p0) x_cnt <= sat_inc(x_cnt);
      if (!fv_p0)                y_cnt <= '0;
      else if (prev_lv && !lv_p0) y_cnt <= sat_inc(y_cnt);
    end
  end

  // ---- stage p0 -> output register: pixel, syncs and its position leave together
  // Output register; overlay colour replaces valid pixels on the crosshair.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oR          <= '0;
      oG          <= '0;
      oB          <= '0;
      oHSync      <= 1'b0;
      oVSync      <= 1'b0;
      oLineValid  <= 1'b0;
      oFrameValid <= 1'b0;
      oX          <= '0;
      oY          <= '0;
    end else begin
      if (ovl_hit) begin
        oR <= OVL_R;
        oG <= OVL_G;
        oB <= OVL_B;
      end else begin
        oR <= r_p0;
        oG <= g_p0;
        oB <= b_p0;
      end
      oHSync      <= hs_p0;
      oVSync      <= vs_p0;
      oLineValid  <= lv_p0;
      oFrameValid <= fv_p0;
      oX          <= x_cnt;
      oY          <= y_cnt;
    end
  end

endmodule

// File: tb/tb_video_stream_switch.sv
// Testbench for video_stream_switch: table of per-cycle input/expected-output records,
// plus a hand-written asynchronous reset sequence.
module tb_video_stream_switch;

  localparam int NUM_SRC = 6;
  localparam int SEL_W   = 4;
  localparam int DATA_W  = 8;
  localparam int POS_W   = 3;

  logic                      iClk = 1'b0;
  logic                      iRst = 1'b0;
  logic [NUM_SRC*DATA_W-1:0] iR, iG, iB;
  logic [NUM_SRC-1:0]        iHSync, iVSync, iLineValid, iFrameValid;
  logic [SEL_W-1:0]          iSel;
  logic                      iOvlEn;
  logic [POS_W-1:0]          iXMark, iYMark;
  logic [DATA_W-1:0]         oR, oG, oB;
  logic                      oHSync, oVSync, oLineValid, oFrameValid;
  logic [POS_W-1:0]          oX, oY;
  logic [SEL_W-1:0]          oSelActive;
  logic                      oPending, oBadSel;

  video_stream_switch #(
    .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DATA_W(DATA_W), .POS_W(POS_W), .OVL_RGB(24'hFF0000)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iR(iR), .iG(iG), .iB(iB),
    .iHSync(iHSync), .iVSync(iVSync), .iLineValid(iLineValid), .iFrameValid(iFrameValid),
    .iSel(iSel), .iOvlEn(iOvlEn), .iXMark(iXMark), .iYMark(iYMark),
    .oR(oR), .oG(oG), .oB(oB), .oHSync(oHSync), .oVSync(oVSync),
    .oLineValid(oLineValid), .oFrameValid(oFrameValid), .oX(oX), .oY(oY),
    .oSelActive(oSelActive), .oPending(oPending), .oBadSel(oBadSel)
  );

  always #5 iClk = ~iClk;

  // One clock cycle: inputs applied before the edge, outputs expected after it.
  // lv/fv are per-source bit masks; src0 carries p0, src2 carries p2, others 0xC0+k.
  typedef struct {
    int sel, lv, fv, p0, p2, ovl, xm, ym;
    int ev, ep, eovl, elv, efv, ex, ey, eact, epend, ebad;
  } vec_t;

  vec_t vq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input int sel, lv, fv, p0, p2, ovl, xm, ym,
                      input int ev, ep, eovl, elv, efv, ex, ey, eact, epend, ebad);
    vec_t v;
    v.sel = sel; v.lv = lv; v.fv = fv; v.p0 = p0; v.p2 = p2;
    v.ovl = ovl; v.xm = xm; v.ym = ym;
    v.ev = ev; v.ep = ep; v.eovl = eovl; v.elv = elv; v.efv = efv;
    v.ex = ex; v.ey = ey; v.eact = eact; v.epend = epend; v.ebad = ebad;
    vq.push_back(v);
  endtask

  // Same as push, without overlay.
  task automatic push_h(input int sel, lv, fv, p0, p2,
                        input int ev, ep, elv, efv, ex, ey, eact, epend, ebad);
    push(sel, lv, fv, p0, p2, 0, 0, 0, ev, ep, 0, elv, efv, ex, ey, eact, epend, ebad);
  endtask

  // A w x h frame on src0 (selected and active), pixel value x+16*y, with blanking around it.
  task automatic add_frame(input int w, h, ovl, xm, ym);
    int ex, p;
    push(0, 0, 0, 0, 0, ovl, xm, ym, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int y = 0; y < h; y++) begin
      push(0, 0, 1, 0, 0, ovl, xm, ym, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      for (int x = 0; x < w; x++) begin
        p  = x + 16 * y;
        ex = (x > 7) ? 7 : x;
        push(0, 1, 1, p, 0, ovl, xm, ym,
             1, p, ((ovl != 0) && (ex == xm || y == ym)) ? 1 : 0, 1, 1, ex, y, 0, 0, 0);
      end
    end
    push(0, 0, 1, 0, 0, ovl, xm, ym, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0, ovl, xm, ym, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drive(input vec_t v);
    logic [DATA_W-1:0] p;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (k == 0)      p = 8'(v.p0);
      else if (k == 2) p = 8'(v.p2);
      else             p = 8'(8'hC0 + k);
      iR[k*DATA_W +: DATA_W] = p;
      iG[k*DATA_W +: DATA_W] = p ^ 8'h55;
      iB[k*DATA_W +: DATA_W] = p ^ 8'hAA;
    end
    iLineValid  = NUM_SRC'(v.lv);
    iFrameValid = NUM_SRC'(v.fv);
    iHSync      = ~NUM_SRC'(v.lv);
    iVSync      = ~NUM_SRC'(v.fv);
    iSel        = SEL_W'(v.sel);
    iOvlEn      = (v.ovl != 0);
    iXMark      = POS_W'(v.xm);
    iYMark      = POS_W'(v.ym);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h expected=%0h", name, idx, got, exp);
    end
  endtask

  task automatic compare(input int i, input vec_t v);
    int er, eg, eb;
    if (v.eovl != 0) begin
      er = 'hFF; eg = 0; eb = 0;
    end else if (v.ev != 0) begin
      er = v.ep; eg = v.ep ^ 'h55; eb = v.ep ^ 'hAA;
    end else begin
      er = 0; eg = 0; eb = 0;
    end
    chk("oR", i, 32'(oR), er);
    chk("oG", i, 32'(oG), eg);
    chk("oB", i, 32'(oB), eb);
    chk("oLineValid", i, 32'(oLineValid), v.elv);
    chk("oFrameValid", i, 32'(oFrameValid), v.efv);
    chk("oHSync", i, 32'(oHSync), 1 - v.elv);
    chk("oVSync", i, 32'(oVSync), 1 - v.efv);
    chk("oSelActive", i, 32'(oSelActive), v.eact);
    chk("oPending", i, 32'(oPending), v.epend);
    chk("oBadSel", i, 32'(oBadSel), v.ebad);
    if (v.ev != 0) begin
      chk("oX", i, 32'(oX), v.ex);
      chk("oY", i, 32'(oY), v.ey);
    end
  endtask

  initial begin
    vec_t v;

    // Plain 4x3 frame, then a 10-wide line that drives oX into saturation, then overlay frame.
    add_frame(4, 3, 0, 0, 0);
    add_frame(10, 1, 0, 0, 0);
    add_frame(4, 3, 1, 2, 1);

    // Cancel: request src2 while src0 is mid-frame, then return to src0 before the boundary.
    push_h(2, 'b000, 'b101, 0,     0, 0, 0,     0, 1, 0, 0, 0, 1, 0);
    push_h(2, 'b001, 'b101, 'h30,  0, 1, 'h30,  1, 1, 0, 0, 0, 1, 0);
    push_h(0, 'b001, 'b101, 'h31,  0, 1, 'h31,  1, 1, 1, 0, 0, 0, 0);
    push_h(0, 'b001, 'b101, 'h32,  0, 1, 'h32,  1, 1, 2, 0, 0, 0, 0);
    push_h(0, 'b000, 'b001, 0,     0, 0, 0,     0, 1, 0, 0, 0, 0, 0);
    push_h(0, 'b000, 'b000, 0,     0, 0, 0,     0, 0, 0, 0, 0, 0, 0);
    push_h(0, 'b000, 'b000, 0,     0, 0, 0,     0, 0, 0, 0, 0, 0, 0);

    // Out-of-range selects (7 and 6 with six sources); a held request survives a bad select.
    push_h(7, 0, 'b000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    push_h(0, 0, 'b000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    push_h(3, 0, 'b000001, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    push_h(6, 0, 'b000001, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    push_h(7, 0, 'b000000, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1);
    push_h(0, 0, 'b000000, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0);
    push_h(0, 0, 'b000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    push_h(0, 0, 'b000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Switch 0 -> 2 mid-frame: src0 keeps flowing until both sources are between frames.
    push_h(0, 'b000, 'b000, 0,    0,    0, 0,    0, 0, 0, 0, 0, 0, 0);
    push_h(2, 'b000, 'b101, 0,    0,    0, 0,    0, 1, 0, 0, 0, 1, 0);
    push_h(2, 'b101, 'b101, 'h10, 'h77, 1, 'h10, 1, 1, 0, 0, 0, 1, 0);
    push_h(2, 'b101, 'b101, 'h11, 'h78, 1, 'h11, 1, 1, 1, 0, 0, 1, 0);
    push_h(2, 'b000, 'b001, 0,    0,    0, 0,    0, 1, 0, 0, 0, 1, 0);
    push_h(2, 'b000, 'b000, 0,    0,    0, 0,    0, 0, 0, 0, 2, 0, 0);
    push_h(2, 'b000, 'b100, 0,    0,    0, 0,    0, 1, 0, 0, 2, 0, 0);
    push_h(2, 'b100, 'b100, 0,    'h20, 1, 'h20, 1, 1, 0, 0, 2, 0, 0);
    push_h(2, 'b000, 'b100, 0,    0,    0, 0,    0, 1, 0, 0, 2, 0, 0);
    push_h(2, 'b000, 'b000, 0,    0,    0, 0,    0, 0, 0, 0, 2, 0, 0);

    // Reset with live inputs on src0 and a bad select: every output must read 0.
    v = '{sel: 7, lv: 1, fv: 1, p0: 'h5A, p2: 0, ovl: 1, xm: 0, ym: 0,
          ev: 0, ep: 0, eovl: 0, elv: 0, efv: 0, ex: 0, ey: 0, eact: 0, epend: 0, ebad: 0};
    drive(v);
    #1 iRst = 1'b1;
    repeat (2) @(posedge iClk);
    #1;
    chk("rst_oR", -1, 32'(oR), 0);
    chk("rst_oG", -1, 32'(oG), 0);
    chk("rst_oB", -1, 32'(oB), 0);
    chk("rst_oHSync", -1, 32'(oHSync), 0);
    chk("rst_oVSync", -1, 32'(oVSync), 0);
    chk("rst_oLineValid", -1, 32'(oLineValid), 0);
    chk("rst_oFrameValid", -1, 32'(oFrameValid), 0);
    chk("rst_oX", -1, 32'(oX), 0);
    chk("rst_oY", -1, 32'(oY), 0);
    chk("rst_oSelActive", -1, 32'(oSelActive), 0);
    chk("rst_oPending", -1, 32'(oPending), 0);
    chk("rst_oBadSel", -1, 32'(oBadSel), 0);
    iRst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i]);
      @(posedge iClk);
      #1;
      compare(i, vq[i]);
    end

    // Asynchronous reset in the middle of a src2 line.
    v = '{sel: 2, lv: 'b100, fv: 'b100, p0: 0, p2: 'h40, ovl: 0, xm: 0, ym: 0,
          ev: 0, ep: 0, eovl: 0, elv: 0, efv: 0, ex: 0, ey: 0, eact: 0, epend: 0, ebad: 0};
    drive(v);
    @(posedge iClk); #1;
    chk("mid_oR0", -2, 32'(oR), 'h40);
    chk("mid_oX0", -2, 32'(oX), 0);
    v.p2 = 'h41;
    drive(v);
    @(posedge iClk); #1;
    chk("mid_oR1", -2, 32'(oR), 'h41);
    chk("mid_oX1", -2, 32'(oX), 1);
    chk("mid_oSelActive", -2, 32'(oSelActive), 2);
    #2 iRst = 1'b1;
    #1;
    chk("arst_oR", -3, 32'(oR), 0);
    chk("arst_oG", -3, 32'(oG), 0);
    chk("arst_oB", -3, 32'(oB), 0);
    chk("arst_oLineValid", -3, 32'(oLineValid), 0);
    chk("arst_oFrameValid", -3, 32'(oFrameValid), 0);
    chk("arst_oX", -3, 32'(oX), 0);
    chk("arst_oSelActive", -3, 32'(oSelActive), 0);
    v = '{sel: 0, lv: 'b001, fv: 'b001, p0: 'h50, p2: 0, ovl: 0, xm: 0, ym: 0,
          ev: 0, ep: 0, eovl: 0, elv: 0, efv: 0, ex: 0, ey: 0, eact: 0, epend: 0, ebad: 0};
    drive(v);
    @(posedge iClk); #1;
    chk("arst_hold_oR", -3, 32'(oR), 0);
    iRst = 1'b0;
    @(posedge iClk); #1;
    chk("post_oR0", -4, 32'(oR), 'h50);
    chk("post_oX0", -4, 32'(oX), 0);
    chk("post_oY0", -4, 32'(oY), 0);
    chk("post_oSelActive", -4, 32'(oSelActive), 0);
    chk("post_oPending", -4, 32'(oPending), 0);
    v.p0 = 'h51;
    drive(v);
    @(posedge iClk); #1;
    chk("post_oR1", -4, 32'(oR), 'h51);
    chk("post_oX1", -4, 32'(oX), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
